// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: shadow-entry layout,
// decode read-mask bit positions and the forwarding-select encoding.
package pipeline_hazard_pkg;

   // Shadow entries carry the widest register index supported; narrower
   // instances zero-extend so the struct stays parameter-free.
   localparam int MAX_REG_AW = 8;

   localparam int RD_RX  = 0;
   localparam int RD_RY  = 1;
   localparam int RD_NZ  = 2;
   localparam int RD_MEM = 3;

   localparam int FWD_REGFILE = 0;

   typedef struct packed {
      logic                  valid;
      logic                  wr_reg_en;
      logic [MAX_REG_AW-1:0] wr_reg;
      logic                  wr_nz;
      logic                  wr_mem;
      logic                  is_load;
   } hazard_entry_t;

endpackage

// File: rtl/pipeline_hazard_unit_match.sv
// Compares one source register index against every shadow entry and reports
// whether any pending writer matches, which one is youngest, and load-use.
module hazard_match #(
   parameter int DEPTH = 3,
   parameter int REG_W = 8,
   parameter int IDX_W = 2
) (
   input  logic [REG_W-1:0]       i_src,
   input  logic [DEPTH-1:0]       i_ent_valid,
   input  logic [DEPTH-1:0]       i_ent_wr_en,
   input  logic [DEPTH*REG_W-1:0] i_ent_wr_reg,
   input  logic                   i_ent0_is_load,
   output logic                   o_hit,
   output logic [IDX_W-1:0]       o_idx,
   output logic                   o_load_use
);

   logic [DEPTH-1:0] w_match;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_match[gi] = i_ent_valid[gi] & i_ent_wr_en[gi]
                         & (i_ent_wr_reg[gi*REG_W +: REG_W] == i_src);
   end

   // Scan oldest to youngest so the lowest matching index wins.
   always_comb begin
      o_idx = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (w_match[k]) begin
            o_idx = IDX_W'(k);
         end
      end
   end

   assign o_hit      = |w_match;
   assign o_load_use = w_match[0] & i_ent0_is_load;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Decode-stage hazard/scoreboard controller with a DEPTH-entry shadow pipeline.
// Define HAZARD_FWD_EN to enable operand forwarding (only load-use stalls).
module pipeline_hazard_unit
   import pipeline_hazard_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_AW   = 3,
   parameter int DEPTH    = 3,
   parameter int CNT_W    = 16,
   localparam int FWD_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   input  logic [3:0]        dec_rd_mask,
   input  logic [REG_AW-1:0] dec_rx,
   input  logic [REG_AW-1:0] dec_ry,
   input  logic              dec_wr_reg_en,
   input  logic [REG_AW-1:0] dec_wr_reg,
   input  logic              dec_wr_nz,
   input  logic              dec_wr_mem,
   input  logic              dec_is_load,
   input  logic              br_flush,
   output logic              stall,
   output logic [FWD_W-1:0]  fwd_sel_x,
   output logic [FWD_W-1:0]  fwd_sel_y,
   output logic [CNT_W-1:0]  stall_count
);

   if (REG_AW != $clog2(NUM_REGS) || REG_AW > MAX_REG_AW || DEPTH < 1) begin : g_bad_params
      $error("pipeline_hazard_unit: inconsistent NUM_REGS/REG_AW/DEPTH");
   end

   hazard_entry_t r_entries [DEPTH];
   hazard_entry_t w_entry_in;
   logic [CNT_W-1:0] r_stall_count;

   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0]            w_wr_en;
   logic [DEPTH-1:0]            w_wr_nz;
   logic [DEPTH-1:0]            w_wr_mem;
   logic [DEPTH-1:0]            w_is_load;
   logic [DEPTH*MAX_REG_AW-1:0] w_wr_reg;

   logic             w_hit_x, w_hit_y;
   logic             w_lu_x, w_lu_y;
   logic [FWD_W-1:0] w_idx_x, w_idx_y;
   logic             w_hz_x, w_hz_y;
   logic             w_nz_hz, w_mem_hz;
   logic             w_reg_stall;
   logic             w_live, w_stall, w_accept;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign w_valid[gi]   = r_entries[gi].valid;
      assign w_wr_en[gi]   = r_entries[gi].wr_reg_en;
      assign w_wr_nz[gi]   = r_entries[gi].wr_nz;
      assign w_wr_mem[gi]  = r_entries[gi].wr_mem;
      assign w_is_load[gi] = r_entries[gi].is_load;
      assign w_wr_reg[gi*MAX_REG_AW +: MAX_REG_AW] = r_entries[gi].wr_reg;
   end

   hazard_match #(
      .DEPTH (DEPTH),
      .REG_W (MAX_REG_AW),
      .IDX_W (FWD_W)
   ) u_match_x (
      .i_src          (MAX_REG_AW'(dec_rx)),
      .i_ent_valid    (w_valid),
      .i_ent_wr_en    (w_wr_en),
      .i_ent_wr_reg   (w_wr_reg),
      .i_ent0_is_load (w_is_load[0]),
      .o_hit          (w_hit_x),
      .o_idx          (w_idx_x),
      .o_load_use     (w_lu_x)
   );

   hazard_match #(
      .DEPTH (DEPTH),
      .REG_W (MAX_REG_AW),
      .IDX_W (FWD_W)
   ) u_match_y (
      .i_src          (MAX_REG_AW'(dec_ry)),
      .i_ent_valid    (w_valid),
      .i_ent_wr_en    (w_wr_en),
      .i_ent_wr_reg   (w_wr_reg),
      .i_ent0_is_load (w_is_load[0]),
      .o_hit          (w_hit_y),
      .o_idx          (w_idx_y),
      .o_load_use     (w_lu_y)
   );

   assign w_hz_x   = dec_rd_mask[RD_RX] & w_hit_x;
   assign w_hz_y   = dec_rd_mask[RD_RY] & w_hit_y;
   // NZ and memory have no forwarding path and no address compare: any writer stalls.
   assign w_nz_hz  = dec_rd_mask[RD_NZ]  & (|(w_valid & w_wr_nz));
   assign w_mem_hz = dec_rd_mask[RD_MEM] & (|(w_valid & w_wr_mem));

`ifdef HAZARD_FWD_EN
   assign w_reg_stall = (w_hz_x & w_lu_x) | (w_hz_y & w_lu_y);
`else
   assign w_reg_stall = w_hz_x | w_hz_y;
`endif

   assign w_live   = dec_valid & ~br_flush;
   assign w_stall  = w_live & (w_reg_stall | w_nz_hz | w_mem_hz);
   assign w_accept = w_live & ~w_stall;

   always_comb begin
      w_entry_in = '0;
      if (w_accept) begin
         w_entry_in.valid     = 1'b1;
         w_entry_in.wr_reg_en = dec_wr_reg_en;
         w_entry_in.wr_reg    = MAX_REG_AW'(dec_wr_reg);
         w_entry_in.wr_nz     = dec_wr_nz;
         w_entry_in.wr_mem    = dec_wr_mem;
         w_entry_in.is_load   = dec_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_entries[k] <= '0;
         end
      end else begin
         r_entries[0] <= w_entry_in;
         for (int k = 1; k < DEPTH; k++) begin
            r_entries[k] <= r_entries[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

`ifdef HAZARD_FWD_EN
   // Forward only on the cycle the consumer actually issues.
   always_comb begin
      fwd_sel_x = FWD_W'(FWD_REGFILE);
      fwd_sel_y = FWD_W'(FWD_REGFILE);
      if (w_accept && w_hz_x) begin
         fwd_sel_x = w_idx_x + FWD_W'(1);
      end
      if (w_accept && w_hz_y) begin
         fwd_sel_y = w_idx_y + FWD_W'(1);
      end
   end

   logic w_unused_bits;
   assign w_unused_bits = ^w_is_load;
`else
   assign fwd_sel_x = FWD_W'(FWD_REGFILE);
   assign fwd_sel_y = FWD_W'(FWD_REGFILE);

   logic w_unused_bits;
   assign w_unused_bits = ^{w_is_load, w_idx_x, w_idx_y, w_lu_x, w_lu_y};
`endif

   assign stall       = w_stall;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed hazard scenarios then
// random traffic, all compared against an issue-time based in-flight model.
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;

   localparam int DEPTH = 3;
   localparam int CNT_W = 4;
   localparam int FWD_W = $clog2(DEPTH + 1);
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             dec_valid;
   logic [3:0]       dec_rd_mask;
   logic [2:0]       dec_rx, dec_ry, dec_wr_reg;
   logic             dec_wr_reg_en, dec_wr_nz, dec_wr_mem, dec_is_load, br_flush;
   logic             stall;
   logic [FWD_W-1:0] fwd_sel_x, fwd_sel_y;
   logic [CNT_W-1:0] stall_count;

   always #5 clk = ~clk;

   pipeline_hazard_unit #(
      .NUM_REGS (8),
      .REG_AW   (3),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dec_valid     (dec_valid),
      .dec_rd_mask   (dec_rd_mask),
      .dec_rx        (dec_rx),
      .dec_ry        (dec_ry),
      .dec_wr_reg_en (dec_wr_reg_en),
      .dec_wr_reg    (dec_wr_reg),
      .dec_wr_nz     (dec_wr_nz),
      .dec_wr_mem    (dec_wr_mem),
      .dec_is_load   (dec_is_load),
      .br_flush      (br_flush),
      .stall         (stall),
      .fwd_sel_x     (fwd_sel_x),
      .fwd_sel_y     (fwd_sel_y),
      .stall_count   (stall_count)
   );

   // Model: list of issued instructions tagged with the cycle they entered EX.
   typedef struct {
      int issued;
      bit wr_reg_en;
      int wr_reg;
      bit wr_nz;
      bit wr_mem;
      bit is_load;
   } instr_t;

   instr_t inflight[$];
   int cyc = 0;
   int model_count = 0;
   int n_pass = 0;
   int n_total = 0;
   bit exp_stall;
   int exp_fx, exp_fy;
   bit last_stall;
   int last_fx;
   int last_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic void reg_lookup(input int src, output bit hit, output int age, output bit ld);
      hit = 0;
      age = DEPTH;
      ld  = 0;
      foreach (inflight[i]) begin
         int a;
         a = cyc - inflight[i].issued;
         if (inflight[i].wr_reg_en && inflight[i].wr_reg == src && a < age) begin
            hit = 1;
            age = a;
            ld  = inflight[i].is_load;
         end
      end
   endfunction

   function automatic void model_eval();
      bit hx, hy, lx, ly, nz, mem, regst, live;
      int ax, ay;
      nz  = 0;
      mem = 0;
      reg_lookup(int'(dec_rx), hx, ax, lx);
      reg_lookup(int'(dec_ry), hy, ay, ly);
      hx = hx & dec_rd_mask[0];
      hy = hy & dec_rd_mask[1];
      foreach (inflight[i]) begin
         nz  = nz  | inflight[i].wr_nz;
         mem = mem | inflight[i].wr_mem;
      end
      nz  = nz  & dec_rd_mask[2];
      mem = mem & dec_rd_mask[3];
      if (FWD) regst = (hx && ax == 0 && lx) || (hy && ay == 0 && ly);
      else     regst = hx || hy;
      live      = dec_valid && !br_flush;
      exp_stall = live && (regst || nz || mem);
      exp_fx    = (FWD && live && !exp_stall && hx) ? ax + 1 : 0;
      exp_fy    = (FWD && live && !exp_stall && hy) ? ay + 1 : 0;
   endfunction

   function automatic void model_update();
      instr_t e;
      cyc++;
      if (reset) begin
         inflight.delete();
         model_count = 0;
      end else begin
         if (exp_stall && model_count < (1 << CNT_W) - 1) model_count++;
         if (dec_valid && !br_flush && !exp_stall) begin
            e.issued    = cyc;
            e.wr_reg_en = dec_wr_reg_en;
            e.wr_reg    = int'(dec_wr_reg);
            e.wr_nz     = dec_wr_nz;
            e.wr_mem    = dec_wr_mem;
            e.is_load   = dec_is_load;
            inflight.push_back(e);
         end
         while (inflight.size() > 0 && cyc - inflight[0].issued >= DEPTH) void'(inflight.pop_front());
      end
   endfunction

   task automatic step(input bit v, input logic [3:0] m, input int rx, input int ry,
                       input bit we, input int wr, input bit wnz, input bit wmem,
                       input bit ld, input bit fl, input bit rs);
      @(negedge clk);
      dec_valid     = v;
      dec_rd_mask   = m;
      dec_rx        = 3'(rx);
      dec_ry        = 3'(ry);
      dec_wr_reg_en = we;
      dec_wr_reg    = 3'(wr);
      dec_wr_nz     = wnz;
      dec_wr_mem    = wmem;
      dec_is_load   = ld;
      br_flush      = fl;
      reset         = rs;
      #1;
      model_eval();
      check("stall", 32'(stall), 32'(exp_stall));
      check("fwd_sel_x", 32'(fwd_sel_x), 32'(exp_fx));
      check("fwd_sel_y", 32'(fwd_sel_y), 32'(exp_fy));
      check("stall_count", 32'(stall_count), 32'(model_count));
      $display("cyc=%0d v=%0b m=%b rx=%0d ry=%0d wr=%0b/%0d nz=%0b mem=%0b ld=%0b fl=%0b rs=%0b -> stall=%0b fx=%0d fy=%0d cnt=%0d",
               cyc, v, m, rx, ry, we, wr, wnz, wmem, ld, fl, rs, stall, fwd_sel_x, fwd_sel_y, stall_count);
      last_stall = stall;
      last_fx    = int'(fwd_sel_x);
      last_count = int'(stall_count);
      @(posedge clk);
      model_update();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Present one instruction until decode accepts it; returns stall cycles and fwd_sel_x.
   task automatic issue(input logic [3:0] m, input int rx, input int ry, input bit we,
                        input int wr, input bit wnz, input bit wmem, input bit ld,
                        output int stalls, output int fx);
      bit done;
      done   = 0;
      stalls = 0;
      fx     = -1;
      for (int k = 0; k < 20 && !done; k++) begin
         step(1, m, rx, ry, we, wr, wnz, wmem, ld, 0, 0);
         if (!last_stall) begin
            fx   = last_fx;
            done = 1;
         end else begin
            stalls++;
         end
      end
      if (!done) check("issue_timeout", 32'(stalls), 32'(0));
   endtask

   initial begin
      int s, f;
      dec_valid = 0; dec_rd_mask = '0; dec_rx = '0; dec_ry = '0;
      dec_wr_reg_en = 0; dec_wr_reg = '0; dec_wr_nz = 0; dec_wr_mem = 0;
      dec_is_load = 0; br_flush = 0; reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_count", 32'(stall_count), 32'(0));
      check("reset_stall", 32'(stall), 32'(0));

      // Back-to-back dependency: add r1 ; add r2,r1
      issue(4'b0000, 0, 0, 1, 1, 0, 0, 0, s, f);
      issue(4'b0001, 1, 0, 1, 2, 0, 0, 0, s, f);
      check("t1_stalls", 32'(s), FWD ? 32'(0) : 32'(3));
      check("t1_fwd", 32'(f), FWD ? 32'(1) : 32'(0));
      idle(DEPTH);

      // One independent instruction between producer and consumer
      issue(4'b0000, 0, 0, 1, 1, 0, 0, 0, s, f);
      issue(4'b0000, 0, 0, 1, 5, 0, 0, 0, s, f);
      issue(4'b0001, 1, 0, 1, 2, 0, 0, 0, s, f);
      check("t2_stalls", 32'(s), FWD ? 32'(0) : 32'(2));
      check("t2_fwd", 32'(f), FWD ? 32'(2) : 32'(0));
      idle(DEPTH);

      // Load-use: ld r3 ; add r4,r3
      do_reset();
      issue(4'b1000, 0, 0, 1, 3, 0, 0, 1, s, f);
      issue(4'b0001, 3, 0, 1, 4, 0, 0, 0, s, f);
      check("t3_stalls", 32'(s), FWD ? 32'(1) : 32'(3));
      check("t3_fwd", 32'(f), FWD ? 32'(2) : 32'(0));
      #1;
      check("t3_count", 32'(stall_count), FWD ? 32'(1) : 32'(3));
      idle(DEPTH);

      // NZ producer then conditional branch
      issue(4'b0000, 0, 0, 0, 0, 1, 0, 0, s, f);
      issue(4'b0100, 0, 0, 0, 0, 0, 0, 0, s, f);
      check("t4_stalls", 32'(s), 32'(3));
      check("t4_fwd", 32'(f), 32'(0));
      idle(DEPTH);

      // Flush overrides a pending hazard and leaves a bubble behind
      issue(4'b0000, 0, 0, 1, 6, 0, 0, 0, s, f);
      step(1, 4'b0001, 6, 0, 1, 2, 0, 0, 0, 1, 0);
      check("t5_flush_stall", 32'(last_stall), 32'(0));
      check("t5_flush_fwd", 32'(last_fx), 32'(0));
      issue(4'b0001, 2, 0, 0, 0, 0, 0, 0, s, f);
      check("t5_after_stalls", 32'(s), 32'(0));
      check("t5_after_fwd", 32'(f), 32'(0));
      idle(DEPTH);

      // Counter saturation, then reset in the middle of a stall
      do_reset();
      for (int k = 0; k < 7; k++) begin
         issue(4'b0000, 0, 0, 0, 0, 1, 0, 0, s, f);
         issue(4'b0100, 0, 0, 0, 0, 0, 0, 0, s, f);
      end
      #1;
      check("t6_saturated", 32'(stall_count), 32'(15));
      issue(4'b0000, 0, 0, 0, 0, 1, 0, 0, s, f);
      step(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t6_pre_reset_stall", 32'(last_stall), 32'(1));
      step(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t6_post_reset_stall", 32'(last_stall), 32'(0));
      check("t6_post_reset_count", 32'(last_count), 32'(0));
      idle(DEPTH);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         bit v, we, wnz, wmem, ld, fl, rs;
         logic [3:0] m;
         v    = ($urandom % 4) != 0;
         m    = {($urandom % 5) == 0, ($urandom % 4) == 0, 1'($urandom), 1'($urandom)};
         we   = 1'($urandom);
         wnz  = ($urandom % 4) == 0;
         wmem = ($urandom % 6) == 0;
         ld   = we && (($urandom % 3) == 0);
         fl   = ($urandom % 10) == 0;
         rs   = ($urandom % 50) == 0;
         step(v, m, int'($urandom_range(7)), int'($urandom_range(7)), we,
              int'($urandom_range(7)), wnz, wmem, ld, fl, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed %0d/%0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule
